jtpang_objdma: RTL and testbench
================================

# jtpang_objdma

Object-attribute DMA engine for the Pang video path. On a CPU `dma_go` strobe it requests the Z80 bus, copies the object attribute table from CPU-side object RAM into the video object buffer one byte per pixel clock enable, then releases the bus. The object line renderer consumes that buffer. It sits between the main CPU bus-arbitration signals (`busrq`/`busak_n`) and the object renderer inside the video subsystem.

## Interface
Parameters:
- `OBJW`, 7: log2 of the object count. Default is 128 objects × 4 bytes = 512 bytes per copy.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cen`  in  1  pixel clock enable (6 MHz); paces every byte transfer.
- `LVBL`  in  1  vertical blank, active low.
- `dma_go`  in  1  DMA request from the main CPU decoder; level, rising edge significant.
- `busrq`  out  1  bus request to the CPU, active high.
- `busak_n`  in  1  bus acknowledge from the CPU, active low.
- `ram_addr`  out  OBJW+2  object RAM read address.
- `ram_dout`  in  8  object RAM data; valid one `cen` after the address.
- `buf_addr`  out  OBJW+3  buffer write address; MSB is the write page.
- `buf_din`  out  8  buffer write data.
- `buf_we`  out  1  buffer write strobe; one `clk` wide, on a `cen` cycle.
- `disp_page`  out  1  page the renderer reads.
- `busy`  out  1  high from request until bus release.
- `done`  out  1  one-`clk` pulse when the bus is released.

## Operation
- FSM states: IDLE, REQ, COPY, DRAIN, REL.
- IDLE: a rising edge on `dma_go`, registered against its previous value, moves the FSM to REQ and sets `busrq=1` and `busy=1`. The address counter clears to 0.
- REQ: waits for `busak_n==0`, sampled on `clk`, then moves to COPY. The wait has no timeout.
- COPY: on each `cen`, `ram_addr` takes the counter value and the counter increments.
  - The data pipeline captures `ram_dout` one `cen` later and asserts `buf_we` with `buf_addr={wr_page, delayed counter}`.
  - After the address `2^(OBJW+2)-1` is issued, the FSM moves to DRAIN.
- DRAIN: performs the final buffer write on the next `cen`, then moves to REL.
- REL: drives `busrq=0`, `busy=0` and a one-`clk` `done` pulse, then returns to IDLE.
- A `dma_go` rising edge while `busy` sets a pending flag. The next DMA starts from IDLE on the cycle after REL. At most one request is pending; further edges are dropped.
- `busak_n` going high during COPY is a protocol violation. It is ignored and the copy completes.
- The counter wraps at `2^(OBJW+2)`. No address beyond the table is ever issued.
- `wr_page` is the complement of `disp_page` (see Configuration).

## Timing
- Reset values: `busrq=0`, `busy=0`, `done=0`, `buf_we=0`, `ram_addr=0`, `buf_addr=0`, `buf_din=0`, `disp_page=0`, pending flag 0, FSM in IDLE.
- Asserting `rst_n` mid-copy drops `busrq` immediately (asynchronous). The partial buffer contents are left as they are.
- Latency with `cen` every clock and `busak_n` low one clock after `busrq`:
  - `dma_go` edge to `busrq`: 1 clk.
  - First `buf_we`: 2 cycles after COPY entry.
  - `busrq` high for 2^(OBJW+2)+4 clk in total (516 clk at the default).
- With `cen` at 1/N of `clk`, every COPY/DRAIN step takes N clk. REQ and REL take one `clk` each, independent of `cen`.
- `buf_we` and the first data byte coincide: `buf_din` equals the RAM byte at address k when `buf_addr[OBJW+1:0]==k`.

## Configuration
- `JTPANG_OBJDMA_DBLBUF_EN` defined:
  - The buffer is double-paged.
  - `done` sets a swap-pending flag.
  - On the next falling edge of `LVBL`, `disp_page` toggles and the flag clears.
  - A DMA that completes after that edge waits for the following vblank.
  - A second `done` before the swap keeps a single pending swap.
- Macro undefined:
  - `disp_page` is fixed at 0 and `wr_page` at 0, so the buffer MSB is always 0.
  - The renderer sees writes in place; tearing is accepted.

## Test plan
- Reset: hold `rst_n=0` with `dma_go=1` → all outputs 0; after release with no new edge, `busrq` stays 0.
- Basic copy, `cen` always 1: RAM preloaded with `data=addr[7:0]^8'h5A`, `busak_n` low 1 clk after `busrq` → exactly 512 `buf_we` pulses, byte k holds k^5A, `busrq` width 516 clk, one `done` pulse.
- Bus latency and slow `cen`: `busak_n` delayed 20 clk, `cen` 1-in-4 → no `ram_addr` change before acknowledge, `buf_we` spacing 4 clk, 512 writes.
- Pending request: second `dma_go` edge at byte 100 and a third at byte 200 → exactly two complete copies back to back; IDLE lasts one clk between them.
- Reset mid-copy: `rst_n` pulsed low at byte 300 → `busrq` falls in the same cycle; a new `dma_go` performs a full 512-byte copy from address 0.
- `JTPANG_OBJDMA_DBLBUF_EN`: `done` at line 100 → `disp_page` toggles 0→1 at the next `LVBL` fall, and the second copy writes page 0 (`buf_addr[9]=0`). Without the macro, `buf_addr[9]` is always 0 and `disp_page` is always 0.

Source files
------------

// File: rtl/jtpang_objdma.sv
// Object-attribute DMA: on a dma_go edge grabs the CPU bus and copies the object table into the object buffer, one byte per cen.
// Latency: busrq 1 clk after the dma_go edge; first buf_we 2 cen after bus acknowledge; no timeout while waiting for busak_n.
// JTPANG_OBJDMA_DBLBUF_EN: double-paged buffer, display page swaps at the first LVBL fall after a completed copy.
module jtpang_objdma #(
  parameter int OBJW = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            LVBL,
  input  logic            dma_go,
  output logic            busrq,
  input  logic            busak_n,
  output logic [OBJW+1:0] ram_addr,
  input  logic [7:0]      ram_dout,
  output logic [OBJW+2:0] buf_addr,
  output logic [7:0]      buf_din,
  output logic            buf_we,
  output logic            disp_page,
  output logic            busy,
  output logic            done
);
  localparam int AW = OBJW + 2;

  typedef enum logic [2:0] {IDLE, REQ, COPY, DRAIN, REL} state_t;

  state_t        state_q;
  logic          go_q;
  logic          pend_q;
  logic          issued_q;
  logic [AW-1:0] cnt_q;
  logic          busrq_q;
  logic          busy_q;
  logic          done_q;
  logic          buf_we_q;
  logic [AW-1:0] ram_addr_q;
  logic [AW:0]   buf_addr_q;
  logic [7:0]    buf_din_q;
  logic          wr_page;
  logic          go_edge;

  assign go_edge = dma_go & ~go_q;

  // go_q resets high so a level already asserted during reset is not taken as a new request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      go_q       <= 1'b1;
      pend_q     <= 1'b0;
      issued_q   <= 1'b0;
      cnt_q      <= '0;
      busrq_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      buf_we_q   <= 1'b0;
      ram_addr_q <= '0;
      buf_addr_q <= '0;
      buf_din_q  <= '0;
    end else begin
      go_q     <= dma_go;
      done_q   <= 1'b0;
      buf_we_q <= 1'b0;
      if (go_edge && busy_q) pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (go_edge || pend_q) begin
            state_q  <= REQ;
            busrq_q  <= 1'b1;
            busy_q   <= 1'b1;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            issued_q <= 1'b0;
          end
        end
        REQ: begin
          if (!busak_n) state_q <= COPY;
        end
        COPY: begin
          if (cen) begin
            ram_addr_q <= cnt_q;
            cnt_q      <= cnt_q + AW'(1);
            issued_q   <= 1'b1;
            // RAM data for the address issued on the previous cen is valid now.
            if (issued_q) begin
              buf_we_q   <= 1'b1;
              buf_din_q  <= ram_dout;
              buf_addr_q <= {wr_page, ram_addr_q};
            end
            if (&cnt_q) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (cen) begin
            buf_we_q   <= 1'b1;
            buf_din_q  <= ram_dout;
            buf_addr_q <= {wr_page, ram_addr_q};
            state_q    <= REL;
          end
        end
        REL: begin
          busrq_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef JTPANG_OBJDMA_DBLBUF_EN
  logic lvbl_q;
  logic swap_q;
  logic swap_d;
  logic disp_page_q;
  logic disp_page_d;

  // A completion arriving on the same cycle as the swap re-arms for the next vblank.
  always_comb begin
    swap_d      = swap_q;
    disp_page_d = disp_page_q;
    if (swap_q && lvbl_q && !LVBL) begin
      disp_page_d = ~disp_page_q;
      swap_d      = 1'b0;
    end
    if (done_q) swap_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvbl_q      <= 1'b1;
      swap_q      <= 1'b0;
      disp_page_q <= 1'b0;
    end else begin
      lvbl_q      <= LVBL;
      swap_q      <= swap_d;
      disp_page_q <= disp_page_d;
    end
  end

  assign wr_page   = ~disp_page_q;
  assign disp_page = disp_page_q;
`else
  logic unused_lvbl;

  assign unused_lvbl = LVBL;
  assign wr_page     = 1'b0;
  assign disp_page   = 1'b0;
`endif

  assign busrq    = busrq_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign buf_we   = buf_we_q;
  assign ram_addr = ram_addr_q;
  assign buf_addr = buf_addr_q;
  assign buf_din  = buf_din_q;

endmodule

// File: tb/tb_jtpang_objdma.sv
// Bench for jtpang_objdma: random table contents, RAM/bus-ack/cen environment and a copy-level reference model.
module tb_jtpang_objdma;
  localparam int N = 512;
`ifdef JTPANG_OBJDMA_DBLBUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       cen;
  logic       LVBL;
  logic       dma_go;
  logic       busrq;
  logic       busak_n;
  logic [8:0] ram_addr;
  logic [7:0] ram_dout;
  logic [9:0] buf_addr;
  logic [7:0] buf_din;
  logic       buf_we;
  logic       disp_page;
  logic       busy;
  logic       done;

  jtpang_objdma #(.OBJW(7)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .LVBL(LVBL), .dma_go(dma_go),
    .busrq(busrq), .busak_n(busak_n), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .buf_addr(buf_addr), .buf_din(buf_din), .buf_we(buf_we),
    .disp_page(disp_page), .busy(busy), .done(done)
  );

  int checks = 0;
  int failures = 0;

  // Environment state and model
  logic [7:0] mem [N];
  int  cen_div = 1;
  int  ack_dly = 1;
  int  ack_cnt = 0;
  int  cen_cnt = 0;
  bit  m_disp  = 1'b0;
  bit  m_swap  = 1'b0;

  // Observations
  int         cyc = 0;
  logic [9:0] wa [$];
  logic [7:0] wd [$];
  int         wc [$];
  int         rises [$];
  int         falls [$];
  int         rq_hi = 0;
  int         done_cnt = 0;
  int         disp_hi = 0;
  logic       rq_prev = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cen divider, synchronous-read RAM, CPU bus acknowledge after ack_dly clocks
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cen_cnt++;
      cen = ((cen_cnt % cen_div) == 0);
      ram_dout = mem[ram_addr];
      if (busrq) begin
        if (ack_cnt >= ack_dly) busak_n = 1'b0;
        else ack_cnt++;
      end else begin
        ack_cnt = 0;
        busak_n = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (buf_we === 1'b1) begin
        wa.push_back(buf_addr);
        wd.push_back(buf_din);
        wc.push_back(cyc);
      end
      if (busrq === 1'b1) rq_hi++;
      if (busrq === 1'b1 && rq_prev !== 1'b1) rises.push_back(cyc);
      if (busrq !== 1'b1 && rq_prev === 1'b1) falls.push_back(cyc);
      if (done === 1'b1) done_cnt++;
      if (disp_page !== 1'b0) disp_hi++;
      rq_prev = busrq;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic clear_mon;
    wa.delete(); wd.delete(); wc.delete(); rises.delete(); falls.delete();
    rq_hi = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_go;
    @(posedge clk); #1 dma_go = 1'b1;
    @(posedge clk); #1 dma_go = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wa.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt >= n) begin ok = 1'b1; break; end
    end
  endtask

  function automatic bit exp_page();
    return DBL ? ~m_disp : 1'b0;
  endfunction

  task automatic randomize_mem;
    for (int k = 0; k < N; k++) mem[k] = 8'($urandom);
  endtask

  task automatic test_reset;
    int hi;
    rst_n = 1'b0; dma_go = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busrq, busy, done, buf_we, disp_page} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busrq/busy/done/buf_we/disp_page=%b want 00000", {busrq, busy, done, buf_we, disp_page});
    end
    checks++;
    if ({ram_addr, buf_addr, buf_din} !== 27'd0) begin
      failures++;
      $display("FAIL reset_bus: ram_addr=%0h buf_addr=%0h buf_din=%0h want all 0", ram_addr, buf_addr, buf_din);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    clear_mon();
    repeat (10) @(negedge clk);
    hi = rq_hi;
    checks++;
    if (hi !== 0) begin
      failures++;
      $display("FAIL reset_no_edge: busrq high for %0d clk want 0", hi);
    end
    dma_go = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_basic;
    logic b0, b1;
    bit ok;
    int bad;
    cen_div = 1; ack_dly = 1;
    for (int k = 0; k < N; k++) mem[k] = 8'(k) ^ 8'h5A;
    clear_mon();
    @(posedge clk); #1 dma_go = 1'b1;
    @(negedge clk); b0 = busrq;
    @(negedge clk); b1 = busrq;
    dma_go = 1'b0;
    checks++;
    if ({b0, b1} !== 2'b01) begin
      failures++;
      $display("FAIL basic_go_to_busrq: busrq before/after edge=%b want 01", {b0, b1});
    end
    wait_done(1, 3000, ok);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || done_cnt !== 1) begin
      failures++;
      $display("FAIL basic_done: done pulses=%0d want 1", done_cnt);
    end
    checks++;
    if (wa.size() !== N) begin
      failures++;
      $display("FAIL basic_writes: buf_we count=%0d want %0d", wa.size(), N);
    end
    bad = 0;
    for (int k = 0; k < N; k++)
      if (wa[k] !== {exp_page(), 9'(k)} || wd[k] !== mem[k]) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL basic_data: %0d bad bytes (first addr=%0h dat=%0h) want 0", bad, wa[0], wd[0]);
    end
    checks++;
    if (rq_hi !== N + 4) begin
      failures++;
      $display("FAIL basic_busrq_width: %0d clk want %0d", rq_hi, N + 4);
    end
    checks++;
    if (wc.size() == 0 || rises.size() == 0 || wc[0] - rises[0] !== 4) begin
      failures++;
      $display("FAIL basic_first_we: busrq-to-first-buf_we=%0d clk want 4", (wc.size() > 0 && rises.size() > 0) ? wc[0] - rises[0] : -1);
    end
    if (DBL) m_swap = 1'b1;
  endtask

  task automatic test_slow_cen;
    logic [8:0] a0;
    bit ok;
    int bad, moved;
    randomize_mem();
    cen_div = 4; ack_dly = 20;
    clear_mon();
    pulse_go();
    a0 = ram_addr;
    moved = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busrq === 1'b1 && busak_n === 1'b0) begin ok = 1'b1; break; end
      if (ram_addr !== a0) moved++;
    end
    checks++;
    if (!ok || moved !== 0) begin
      failures++;
      $display("FAIL slow_pre_ack: ram_addr changed %0d times before ack (ack seen=%0d) want 0", moved, ok);
    end
    wait_done(1, 5000, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || wa.size() !== N) begin
      failures++;
      $display("FAIL slow_writes: buf_we count=%0d want %0d", wa.size(), N);
    end
    bad = 0;
    for (int k = 0; k < N; k++)
      if (wa[k] !== {exp_page(), 9'(k)} || wd[k] !== mem[k]) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL slow_data: %0d bad bytes want 0", bad);
    end
    bad = 0;
    for (int i = 1; i < wc.size(); i++)
      if (wc[i] - wc[i-1] !== 4) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL slow_spacing: %0d buf_we gaps differ from 4 clk want 0", bad);
    end
    cen_div = 1; ack_dly = 1;
  endtask

  task automatic test_back_to_back;
    bit ok;
    int bad;
    randomize_mem();
    clear_mon();
    pulse_go();
    wait_writes(100, 2000, ok);
    pulse_go();
    wait_writes(200, 2000, ok);
    pulse_go();
    wait_done(2, 4000, ok);
    repeat (600) @(negedge clk);
    checks++;
    if (!ok || done_cnt !== 2 || rises.size() !== 2) begin
      failures++;
      $display("FAIL b2b_count: done=%0d busrq_rises=%0d want 2 and 2", done_cnt, rises.size());
    end
    checks++;
    if (wa.size() !== 2 * N) begin
      failures++;
      $display("FAIL b2b_writes: buf_we count=%0d want %0d", wa.size(), 2 * N);
    end
    bad = 0;
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < N; k++)
        if (wa[c*N+k] !== {exp_page(), 9'(k)} || wd[c*N+k] !== mem[k]) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL b2b_data: %0d bad bytes want 0", bad);
    end
    checks++;
    if (rises.size() < 2 || falls.size() < 1 || rises[1] - falls[0] !== 1) begin
      failures++;
      $display("FAIL b2b_gap: busrq low for %0d clk between copies want 1", (rises.size() > 1 && falls.size() > 0) ? rises[1] - falls[0] : -1);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int bad;
    logic r, b;
    randomize_mem();
    clear_mon();
    pulse_go();
    wait_writes(300, 2000, ok);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 r = busrq; b = busy;
    checks++;
    if (!ok || r !== 1'b0 || b !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async: busrq=%b busy=%b within reset cycle want 0 0", r, b);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_disp = 1'b0; m_swap = 1'b0;
    repeat (2) @(negedge clk);
    clear_mon();
    repeat (5) @(negedge clk);
    pulse_go();
    wait_done(1, 3000, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || wa.size() !== N) begin
      failures++;
      $display("FAIL rstmid_writes: buf_we count=%0d want %0d", wa.size(), N);
    end
    bad = 0;
    for (int k = 0; k < N; k++)
      if (wa[k] !== {exp_page(), 9'(k)} || wd[k] !== mem[k]) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL rstmid_data: %0d bad bytes want 0", bad);
    end
    if (DBL) m_swap = 1'b1;
  endtask

  task automatic vblank_fall;
    @(posedge clk); #1 LVBL = 1'b0;
    if (m_swap) begin m_disp = ~m_disp; m_swap = 1'b0; end
    repeat (3) @(posedge clk); #1 LVBL = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_paging;
    bit ok;
    int bad;
`ifdef JTPANG_OBJDMA_DBLBUF_EN
    // Swap from earlier copies is pending; this vblank toggles the page.
    vblank_fall();
    checks++;
    if (disp_page !== m_disp) begin
      failures++;
      $display("FAIL page_swap1: disp_page=%b want %b", disp_page, m_disp);
    end
    for (int c = 0; c < 2; c++) begin
      randomize_mem();
      clear_mon();
      pulse_go();
      wait_done(1, 3000, ok);
      repeat (2) @(negedge clk);
      m_swap = 1'b1;
      bad = 0;
      for (int k = 0; k < N; k++)
        if (wa[k] !== {exp_page(), 9'(k)} || wd[k] !== mem[k]) bad++;
      checks++;
      if (!ok || wa.size() !== N || bad !== 0) begin
        failures++;
        $display("FAIL page_copy%0d: writes=%0d bad=%0d want %0d 0 page %b", c, wa.size(), bad, N, exp_page());
      end
      checks++;
      if (disp_page !== m_disp) begin
        failures++;
        $display("FAIL page_hold%0d: disp_page=%b before vblank want %b", c, disp_page, m_disp);
      end
    end
    vblank_fall();
    checks++;
    if (disp_page !== m_disp) begin
      failures++;
      $display("FAIL page_swap2: disp_page=%b want %b", disp_page, m_disp);
    end
    vblank_fall();
    checks++;
    if (disp_page !== m_disp) begin
      failures++;
      $display("FAIL page_single_swap: disp_page=%b want %b", disp_page, m_disp);
    end
`else
    randomize_mem();
    clear_mon();
    pulse_go();
    for (int i = 0; i < 3; i++) begin
      repeat (50) @(negedge clk);
      vblank_fall();
    end
    wait_done(1, 3000, ok);
    vblank_fall();
    bad = 0;
    for (int k = 0; k < wa.size(); k++)
      if (wa[k][9] !== 1'b0) bad++;
    checks++;
    if (!ok || wa.size() !== N || bad !== 0) begin
      failures++;
      $display("FAIL page_single: writes=%0d page1_writes=%0d want %0d 0", wa.size(), bad, N);
    end
    checks++;
    if (disp_hi !== 0) begin
      failures++;
      $display("FAIL page_disp_fixed: disp_page high for %0d clk want 0", disp_hi);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0; dma_go = 1'b1; cen = 1'b1; LVBL = 1'b1;
    busak_n = 1'b1; ram_dout = 8'h00;
    test_reset();
    test_basic();
    test_slow_cen();
    test_back_to_back();
    test_reset_mid();
    test_paging();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
